iterative_muldiv_unit: RTL and testbench

//  Multi-cycle RV32M execution unit. Beside the single-cycle ALU in the EX stage.

---
 rtl/iterative_muldiv_unit.sv | 131 +++++++++++++
 tb/tb_iterative_muldiv_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle RV32M unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up and a single-cycle done pulse.
module iterative_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;

  logic              accept, last_step;
  logic              a_signed, b_signed, sa_in, sb_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  // Operand decode and the divide special cases resolved at acceptance
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                 a_signed = 1'b1;
      default: ;
    endcase
    sa_in    = a_signed & rs1[XLEN-1];
    sb_in    = b_signed & rs2[XLEN-1];
    a_mag    = sa_in ? -rs1 : rs1;
    b_mag    = sb_in ? -rs2 : rs2;
    div_zero = (rs2 == '0);
    div_ovf  = (funct3 == 3'b100 || funct3 == 3'b110) &&
               (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    fast     = funct3[2] & (div_zero | div_ovf);
    if (div_zero) fast_res = funct3[1] ? rs1 : '1;
    else          fast_res = funct3[1] ? '0 : rs1;
    accept    = (state == S_IDLE) && start && !kill;
    last_step = (count == CW'(XLEN-1));
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, opnd};
    div_next = {(div_diff[XLEN] ? rem_sh[XLEN-1:0] : div_diff[XLEN-1:0]),
                acc[XLEN-2:0], ~div_diff[XLEN]};
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quot_fix = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op[2])              fix_res = op[1] ? rem_fix : quot_fix;
    else if (op[1:0] == '0) fix_res = prod_fix[XLEN-1:0];
    else                    fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = fast ? S_DONE : (funct3[2] ? S_DIV : S_MUL);
      S_MUL:   if (last_step) state_nxt = S_FIXUP;
      S_DIV:   if (last_step) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op     <= funct3;
          sign_a <= sa_in;
          sign_b <= sb_in;
          count  <= '0;
          opnd   <= funct3[2] ? b_mag : a_mag;
          acc    <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
          if (fast) result <= fast_res;
        end
        S_MUL: begin
          acc   <= mul_next;
          count <= count + CW'(1);
        end
        S_DIV: begin
          acc   <= div_next;
          count <= count + CW'(1);
        end
        S_FIXUP: if (!kill) result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Directed self-checking bench for iterative_muldiv_unit (XLEN=32).
module tb_iterative_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] last_exp = '0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  iterative_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive a request for one cycle, then scramble the inputs; returns at the
  // falling edge of the first cycle after acceptance.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name,
                        input int restart_at);
    int n;
    logic busy_ok;
    logic extra;
    busy_ok = 1'b1;
    extra   = 1'b0;
    issue(f, a, b);
    n = 1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (restart_at != 0 && n == restart_at) begin
        start = 1'b1; funct3 = 3'b101; rs1 = 32'd5; rs2 = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!busy) busy_ok = 1'b0;
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_result"}, result, exp);
    check({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
    last_exp = exp;
    @(negedge clk);
    check({name, "_pulse_end"}, {30'd0, done, busy}, 32'd0);
    if (restart_at != 0) begin
      for (int i = 0; i < 5; i++) begin
        if (done || busy) extra = 1'b1;
        @(negedge clk);
      end
      check({name, "_no_requeue"}, {31'd0, extra}, 32'd0);
    end
  endtask

  initial begin
    logic seen;
    reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    #12;
    check("reset_state", {busy, done, result[29:0]}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    add_vec(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7_m3");
    add_vec(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_max");
    add_vec(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, "mulh_m1");
    add_vec(3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34, "mulhsu");
    add_vec(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min");
    add_vec(3'b011, 32'h80000000, 32'h00000002, 32'h00000001, 34, "mulhu_carry");
    add_vec(3'b000, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 34, "mul_ffff");
    add_vec(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div_m7_2");
    add_vec(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem_m7_2");
    add_vec(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, "div_7_m2");
    add_vec(3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 34, "rem_7_m2");
    add_vec(3'b101, 32'd100,      32'd7,        32'd14,       34, "divu_100_7");
    add_vec(3'b111, 32'd100,      32'd7,        32'd2,        34, "remu_100_7");
    add_vec(3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34, "divu_max_1");
    add_vec(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_by0");
    add_vec(3'b111, 32'd5,        32'd0,        32'd5,        1,  "remu_by0");
    add_vec(3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1,  "div_by0");
    add_vec(3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  "rem_by0");
    add_vec(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");
    add_vec(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf");

    foreach (vecs[i])
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, 0);

    // Second start mid-MUL must be ignored
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_restart", 10);

    // Kill mid-MUL: no done, result keeps the previous completion
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, "divu_pre_kill", 0);
    issue(3'b000, 32'd3, 32'd3);
    for (int n = 1; n < 15; n++) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_idle", {30'd0, busy, done}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    check("kill_no_done", {31'd0, seen}, 32'd0);
    check("kill_result", result, last_exp);

    // Kill and start together in IDLE: request dropped
    start = 1'b1; kill = 1'b1; funct3 = 3'b101; rs1 = 32'd5; rs2 = 32'd0;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    check("kill_start_drop", {31'd0, seen}, 32'd0);
    check("kill_start_result", result, last_exp);

    // Asynchronous reset between clock edges during a DIV
    issue(3'b100, 32'd1000, 32'd3);
    for (int n = 1; n < 10; n++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ctrl", {30'd0, busy, done}, 32'd0);
    check("async_rst_result", result, 32'd0);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("rst_no_stale", {31'd0, seen}, 32'd0);
    run_op(3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34, "div_after_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
